alu_share_ctrl: RTL and testbench
=================================

// Module: alu_share_ctrl
// PURPOSE
//  Shares one 7-bit NAND/ROL ALU between two requesters. Round-robin arbitration,
//  operands and result registered, responses returned in a single tagged channel.
//  Sits between the instruction-issue logic and the ALU; one operation in flight.
// PARAMETERS
//  DATA_W  7  operand/result width; fixed at 7 to match the ALU
//  CNT_W   8  width of completed-operation counter ops_done
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  req0_valid in   1       requester 0 has an operation
//  req0_ready out  1       requester 0 accepted this cycle
//  req0_a     in   DATA_W  operand A
//  req0_b     in   DATA_W  operand B (ROL uses b[2:0])
//  req0_op    in   2       00 NAND, 01 ROL, 1x illegal
//  req1_*     --   --      identical set for requester 1
//  rsp_valid  out  1       result available
//  rsp_ready  in   1       consumer takes result
//  rsp_id     out  1       requester that issued the op
//  rsp_r      out  DATA_W  ALU result
//  rsp_err    out  1       op was illegal (1x); rsp_r = 0
//  busy       out  1       state != IDLE
//  ops_done   out  CNT_W   count of rsp handshakes, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (async): state=IDLE, rsp_valid=0, rsp_id=0, rsp_r=0, rsp_err=0,
//    ops_done=0, last_grant=1 (requester 0 wins first tie), operand regs=0.
//  - FSM IDLE -> EXEC -> RESP -> IDLE.
//  - IDLE: reqN_ready combinational: high only for the granted requester.
//    One valid -> grant it. Both valid -> grant !last_grant. None -> stay.
//    On handshake latch a,b,op,id; last_grant<=id; go EXEC.
//  - EXEC (1 cycle): ALU driven from latched regs; capture rsp_r, rsp_err
//    (op[1]==1 forces rsp_r=0, rsp_err=1); go RESP.
//  - RESP: rsp_valid=1, payload stable until rsp_valid&rsp_ready; on that edge
//    ops_done++ (wraps), go IDLE. Both req_ready low outside IDLE.
//  - Latency: accept in cycle 0, rsp_valid first high in cycle 2; min 3 cycles/op.
//  - No back-to-back issue: a request valid during RESP waits; no starvation since
//    a waiting requester always wins the next tie.
//  - req valid may drop without handshake; not latched, no side effect.
//  - rsp_ready held low: stay in RESP indefinitely, requests stall.
//  - Reset mid-operation: in-flight op discarded, no response emitted.
//  - Requester valid must not depend combinationally on its ready.
// STRUCTURE
//  - Shared package alu_pkg: DATA_W, OP_NAND=2'b00, OP_ROL=2'b01, state enum
//    {IDLE,EXEC,RESP}.
//  - One sub-module: existing ALU instantiated once, fed from latched operands.
//  - Arbiter kept inline (two requesters; a separate module is not warranted).
// TESTING
//  1 Reset, then req0 NAND a=7'h55 b=7'h0F -> rsp_valid cycle 2, rsp_id=0,
//    rsp_r=7'h7A, rsp_err=0, ops_done=1 after handshake.
//  2 req1 ROL a=7'h41 b=7'h01 -> rsp_id=1, rsp_r=7'h03.
//  3 Both valid every cycle from reset -> grants 0,1,0,1; rsp_id alternates;
//    neither ready high outside IDLE.
//  4 req0 op=2'b10 a=7'h7F -> rsp_err=1, rsp_r=7'h00.
//  5 rsp_ready low 10 cycles in RESP -> payload stable, req readys low, busy=1;
//    raise -> IDLE next cycle, ops_done increments once.
//  6 Assert rst during EXEC -> all outputs reset values immediately, no rsp; with
//    CNT_W=2, 4 ops complete -> ops_done wraps to 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU controller and its ALU.
package alu_pkg;

    localparam int unsigned DATA_W = 7;

    localparam logic [1:0] OP_NAND = 2'b00;
    localparam logic [1:0] OP_ROL  = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// 7-bit NAND / rotate-left ALU, purely combinational.
module alu_share_ctrl_alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [1:0]        i_op,
    output logic [DATA_W-1:0] o_r
);

    logic [2*DATA_W-1:0] w_rot;

    // Rotate by shifting a doubled copy; the upper half holds the rotated value.
    assign w_rot = {i_a, i_a} << i_b[2:0];

    // Select the result; illegal opcodes give zero.
    always_comb begin
        o_r = '0;
        case (i_op)
            OP_NAND: o_r = ~(i_a & i_b);
            OP_ROL:  o_r = w_rot[2*DATA_W-1:DATA_W];
            default: o_r = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one NAND/ROL ALU between two requesters, one op in flight.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [1:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [1:0]        req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_r,
    output logic              rsp_err,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_done
);

    state_t              r_state;
    state_t              w_state_next;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [1:0]          r_op;
    logic                r_id;
    logic                r_last_grant;
    logic [DATA_W-1:0]   r_rsp_r;
    logic                r_rsp_err;
    logic [CNT_W-1:0]    r_ops_done;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_accept;
    logic                w_rsp_hs;
    logic [DATA_W-1:0]   w_alu_r;

    alu_share_ctrl_alu u_alu (
        .i_a  (r_a),
        .i_b  (r_b),
        .i_op (r_op),
        .o_r  (w_alu_r)
    );

    // Arbitration and next state; a tie goes to whoever did not win last time.
    always_comb begin
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                w_grant0 = req0_valid && (!req1_valid || r_last_grant);
                w_grant1 = req1_valid && (!req0_valid || !r_last_grant);
                if (w_grant0 || w_grant1) begin
                    w_state_next = EXEC;
                end
            end
            EXEC: w_state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_accept = w_grant0 || w_grant1;
    assign w_rsp_hs = (r_state == RESP) && rsp_ready;

    // State, operand latch, result capture and completion counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_rsp_r      <= '0;
            r_rsp_err    <= 1'b0;
            r_ops_done   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a          <= w_grant1 ? req1_a  : req0_a;
                r_b          <= w_grant1 ? req1_b  : req0_b;
                r_op         <= w_grant1 ? req1_op : req0_op;
                r_id         <= w_grant1;
                r_last_grant <= w_grant1;
            end
            if (r_state == EXEC) begin
                r_rsp_r   <= r_op[1] ? '0 : w_alu_r;
                r_rsp_err <= r_op[1];
            end
            if (w_rsp_hs) begin
                r_ops_done <= r_ops_done + CNT_W'(1);
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_id     = r_id;
    assign rsp_r      = r_rsp_r;
    assign rsp_err    = r_rsp_err;
    assign busy       = (r_state != IDLE);
    assign ops_done   = r_ops_done;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl; a second instance with a 2-bit counter checks wrap.
module tb_alu_share_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [6:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0] req0_op = '0, req1_op = '0;
    logic       rsp_ready = 1'b1;
    logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, busy;
    logic [6:0] rsp_r;
    logic [7:0] ops_done;
    logic       w2_req0_ready, w2_req1_ready, w2_rsp_valid, w2_rsp_id, w2_rsp_err, w2_busy;
    logic [6:0] w2_rsp_r;
    logic [1:0] w2_ops_done;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] sb[$];          // {id, err, r}
    int         grant_log[$];
    int         exp_ops = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_r(rsp_r),
        .rsp_err(rsp_err), .busy(busy), .ops_done(ops_done)
    );

    alu_share_ctrl #(.CNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(w2_req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(w2_req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(w2_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(w2_rsp_id),
        .rsp_r(w2_rsp_r), .rsp_err(w2_rsp_err), .busy(w2_busy), .ops_done(w2_ops_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference ALU, built bitwise rather than by shifting a doubled word.
    function automatic logic [8:0] model(input logic id, input logic [6:0] a,
                                         input logic [6:0] b, input logic [1:0] op);
        logic [6:0] r;
        r = a;
        if (op[1]) return {id, 1'b1, 7'h00};
        if (op == 2'b00) return {id, 1'b0, ~(a & b)};
        for (int i = 0; i < int'(b[2:0]); i++) r = {r[5:0], r[6]};
        return {id, 1'b0, r};
    endfunction

    // Monitor: push on accept, pop on response, track the counter and idle-only readiness.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            sb.delete();
            exp_ops = 0;
            check("rst_outs", {rsp_valid, busy, rsp_id, rsp_err, rsp_r, ops_done}, 32'h0);
            check("rst_w2_ops", {30'h0, w2_ops_done}, 32'h0);
        end else begin
            check("ops_done", {24'h0, ops_done}, exp_ops & 32'hFF);
            check("ops_done_w2", {30'h0, w2_ops_done}, exp_ops & 32'h3);
            check("ready_onehot", {31'h0, req0_ready & req1_ready}, 32'h0);
            if (busy) check("ready_busy", {30'h0, req0_ready, req1_ready}, 32'h0);
            if (req0_valid && req0_ready) begin
                sb.push_back(model(1'b0, req0_a, req0_b, req0_op));
                grant_log.push_back(0);
            end
            if (req1_valid && req1_ready) begin
                sb.push_back(model(1'b1, req1_a, req1_b, req1_op));
                grant_log.push_back(1);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_rsp", 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", {31'h0, rsp_id}, {31'h0, e[8]});
                    check("rsp_err", {31'h0, rsp_err}, {31'h0, e[7]});
                    check("rsp_r", {25'h0, rsp_r}, {25'h0, e[6:0]});
                end
                exp_ops++;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && !rsp_valid) return;
        end
        check("timeout_idle", 32'h1, 32'h0);
    endtask

    task automatic issue(input logic id, input logic [6:0] a, input logic [6:0] b,
                         input logic [1:0] op);
        @(posedge clk); #1;
        if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
        else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) break;
            if (i == 49) check("timeout_accept", 32'h1, 32'h0);
        end
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    logic [8:0] held;
    logic [7:0] ops_before;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset, then a single NAND with exact latency
        do_reset();
        @(negedge clk);
        check("idle_ready", {30'h0, req0_ready, req1_ready}, 32'h0);
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 7'h55; req0_b = 7'h0F; req0_op = 2'b00;
        @(negedge clk);
        check("t1_ready_c0", {31'h0, req0_ready}, 32'h1);
        @(posedge clk); #1 req0_valid = 0;
        @(negedge clk);
        check("t1_c1", {30'h0, rsp_valid, busy}, 32'h1);
        @(negedge clk);
        check("t1_valid_c2", {31'h0, rsp_valid}, 32'h1);
        check("t1_r", {25'h0, rsp_r}, 32'h7A);
        @(negedge clk);
        check("t1_ops", {24'h0, ops_done}, 32'h1);

        // 2: requester 1 ROL
        wait_idle();
        issue(1'b1, 7'h41, 7'h01, 2'b01);
        wait_idle();

        // 4: illegal opcode, plus a couple of varied patterns
        issue(1'b0, 7'h7F, 7'h12, 2'b10);
        issue(1'b1, 7'h6B, 7'h07, 2'b01);
        issue(1'b0, 7'h00, 7'h00, 2'b00);
        issue(1'b1, 7'h33, 7'h55, 2'b11);
        wait_idle();

        // 5: consumer stalls for 10 cycles while both requesters wait
        rsp_ready = 0;
        issue(1'b0, 7'h2C, 7'h05, 2'b01);
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        check("t5_valid", {31'h0, rsp_valid}, 32'h1);
        held = {rsp_id, rsp_err, rsp_r};
        ops_before = ops_done;
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 7'h11; req0_b = 7'h22; req0_op = 2'b00;
        req1_valid = 1; req1_a = 7'h0E; req1_b = 7'h02; req1_op = 2'b01;
        repeat (10) begin
            @(negedge clk);
            check("t5_payload", {23'h0, rsp_id, rsp_err, rsp_r}, {23'h0, held});
            check("t5_busy_valid", {30'h0, busy, rsp_valid}, 32'h3);
        end
        @(posedge clk); #1 rsp_ready = 1;
        @(negedge clk);
        @(negedge clk);
        check("t5_idle", {31'h0, busy}, 32'h0);
        check("t5_ops", {24'h0, ops_done}, {24'h0, ops_before + 8'd1});
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        wait_idle();

        // 3: both valid continuously from reset -> grants 0,1,0,1
        @(posedge clk); #1 rst = 1;
        req0_valid = 1; req0_a = 7'h2A; req0_b = 7'h33; req0_op = 2'b00;
        req1_valid = 1; req1_a = 7'h15; req1_b = 7'h03; req1_op = 2'b01;
        grant_log.delete();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 100 && grant_log.size() < 4; i++) @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        wait_idle();
        check("t3_ngrants", (grant_log.size() >= 4) ? 32'h1 : 32'h0, 32'h1);
        if (grant_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("t3_grant", grant_log[i], i % 2);
        end

        // 6: reset while in EXEC discards the op; then four ops wrap the 2-bit counter
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 7'h01; req0_b = 7'h01; req0_op = 2'b01;
        @(posedge clk); #1;
        req0_valid = 0;
        check("t6_in_exec", {30'h0, busy, rsp_valid}, 32'h2);
        rst = 1;
        #1;
        check("t6_rst_now", {rsp_valid, busy, rsp_id, rsp_err, rsp_r, ops_done}, 32'h0);
        @(posedge clk); #1 rst = 0;
        repeat (4) @(negedge clk);
        check("t6_no_rsp", {30'h0, rsp_valid, busy}, 32'h0);
        for (int i = 0; i < 4; i++) issue(i[0], 7'(i * 19 + 3), 7'(i + 1), 2'(i % 2));
        wait_idle();
        check("t6_ops4", {24'h0, ops_done}, 32'h4);
        check("t6_wrap", {30'h0, w2_ops_done}, 32'h0);
        check("sb_drained", sb.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
